// File: rtl/syn_peak_detector_if.sv
// Correlator-to-sync interface: window/sample stream into the peak detector and
// the coarse/fine sync results coming back out.
interface syn_peak_detector_if #(
    parameter int MAG_W = 24
);
    logic             win_start;
    logic             corr_valid;
    logic [MAG_W-1:0] corr_mag;
    logic             corase_syn_en;
    logic [31:0]      corase_syn_pos;
    logic             fine_syn_en;
    logic [31:0]      fine_syn_pos;
    logic             lose;
    logic [1:0]       det_state;

    modport master (
        output win_start, corr_valid, corr_mag,
        input  corase_syn_en, corase_syn_pos, fine_syn_en, fine_syn_pos, lose, det_state
    );

    modport slave (
        input  win_start, corr_valid, corr_mag,
        output corase_syn_en, corase_syn_pos, fine_syn_en, fine_syn_pos, lose, det_state
    );
endinterface

// File: rtl/syn_peak_detector.sv
// Slot peak detector: per-window peak search, coarse-sync confirmation, then tracking with loss detection.
// Optional macro SYN_TRACK_UPDATE_EN: each tracking hit re-centres ref_pos on the new peak.
module syn_peak_detector #(
    parameter int MAG_W     = 24,
    parameter int CONFIRM_N = 3,
    parameter int LOSE_N    = 4,
    parameter int TOL       = 8
) (
    input  logic                  clk_50m,
    input  logic                  cfg_rst_n,
    input  logic                  sync_clr,
    input  logic [MAG_W-1:0]      cfg_thresh,
    syn_peak_detector_if.slave    bus
);
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam int HC_W = $clog2(CONFIRM_N + 1);
    localparam int MC_W = $clog2(LOSE_N + 1);
    localparam logic [HC_W-1:0] CONFIRM_TGT = HC_W'(CONFIRM_N);
    localparam logic [MC_W-1:0] LOSE_TGT    = MC_W'(LOSE_N);

    state_t           state;
    logic             window_open;
    logic             has_sample;
    logic [31:0]      offset;
    logic [MAG_W-1:0] peak_mag;
    logic [31:0]      peak_off;
    logic [31:0]      ref_pos;
    logic [HC_W-1:0]  hit_cnt;
    logic [MC_W-1:0]  miss_cnt;

    logic             hit;
    logic             near;
    logic [32:0]      diff;
    logic [32:0]      abs_diff;
    logic [HC_W-1:0]  hit_cnt_inc;
    logic [MC_W-1:0]  miss_cnt_inc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hit          = 1'b0;
        near         = 1'b0;
        diff         = {1'b0, peak_off} - {1'b0, ref_pos};
        abs_diff     = diff[32] ? (~diff + 33'd1) : diff;
        hit_cnt_inc  = hit_cnt + 1'b1;
        miss_cnt_inc = miss_cnt + 1'b1;
        if (has_sample && (peak_mag >= cfg_thresh)) begin
            hit  = 1'b1;
            near = (abs_diff <= 33'(TOL));
        end
    end

    assign bus.det_state = state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            state              <= SEARCH;
            window_open        <= 1'b0;
            has_sample         <= 1'b0;
            offset             <= '0;
            peak_mag           <= '0;
            peak_off           <= '0;
            ref_pos            <= '0;
            hit_cnt            <= '0;
            miss_cnt           <= '0;
            bus.corase_syn_en  <= 1'b0;
            bus.corase_syn_pos <= '0;
            bus.fine_syn_en    <= 1'b0;
            bus.fine_syn_pos   <= '0;
            bus.lose           <= 1'b0;
        end else begin
            bus.corase_syn_en <= 1'b0;
            bus.fine_syn_en   <= 1'b0;
            if (sync_clr) begin
                state       <= SEARCH;
                window_open <= 1'b0;
                has_sample  <= 1'b0;
                offset      <= '0;
                peak_mag    <= '0;
                peak_off    <= '0;
                ref_pos     <= '0;
                hit_cnt     <= '0;
                miss_cnt    <= '0;
                bus.lose    <= 1'b0;
            end else begin
                // A sample arriving with win_start is offset 0 of the new window.
                if (bus.win_start) begin
                    window_open <= 1'b1;
                    peak_off    <= '0;
                    peak_mag    <= bus.corr_valid ? bus.corr_mag : '0;
                    offset      <= bus.corr_valid ? 32'd1 : 32'd0;
                    has_sample  <= bus.corr_valid;
                end else if (bus.corr_valid) begin
                    if (bus.corr_mag > peak_mag) begin
                        peak_mag <= bus.corr_mag;
                        peak_off <= offset;
                    end
                    if (offset != 32'hFFFF_FFFF) offset <= offset + 32'd1;
                    has_sample <= 1'b1;
                end

                if (bus.win_start && window_open) begin
                    case (state)
                        SEARCH: begin
                            if (hit) begin
                                ref_pos <= peak_off;
                                hit_cnt <= HC_W'(1);
                                if (CONFIRM_N == 1) begin
                                    state              <= TRACK;
                                    bus.corase_syn_en  <= 1'b1;
                                    bus.corase_syn_pos <= peak_off;
                                    bus.lose           <= 1'b0;
                                    miss_cnt           <= '0;
                                end else begin
                                    state <= CONFIRM;
                                end
                            end
                        end
                        CONFIRM: begin
                            if (near) begin
                                hit_cnt <= hit_cnt_inc;
                                if (hit_cnt_inc == CONFIRM_TGT) begin
                                    state              <= TRACK;
                                    bus.corase_syn_en  <= 1'b1;
                                    bus.corase_syn_pos <= ref_pos;
                                    bus.lose           <= 1'b0;
                                    miss_cnt           <= '0;
                                end
                            end else if (hit) begin
                                ref_pos <= peak_off;
                                hit_cnt <= HC_W'(1);
                            end else begin
                                state   <= SEARCH;
                                hit_cnt <= '0;
                            end
                        end
                        TRACK: begin
                            if (near) begin
                                bus.fine_syn_en  <= 1'b1;
                                bus.fine_syn_pos <= peak_off;
                                miss_cnt         <= '0;
`ifdef SYN_TRACK_UPDATE_EN
                                ref_pos          <= peak_off;
`endif
                            end else if (miss_cnt_inc == LOSE_TGT) begin
                                bus.lose <= 1'b1;
                                state    <= SEARCH;
                                hit_cnt  <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt_inc;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_syn_peak_detector.sv
// Directed bench for syn_peak_detector: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares them; state/lose levels are checked inline.
module tb_syn_peak_detector;
    localparam int MAG_W = 24;

    typedef struct {
        bit          coarse;
        logic [31:0] pos;
    } exp_t;

    logic             clk_50m = 1'b0;
    logic             cfg_rst_n = 1'b0;
    logic             sync_clr = 1'b0;
    logic [MAG_W-1:0] cfg_thresh = 24'd100;
    int               checks = 0;
    int               errors = 0;
    exp_t             exp_q[$];

    syn_peak_detector_if #(.MAG_W(MAG_W)) bus ();

    syn_peak_detector #(.MAG_W(MAG_W), .CONFIRM_N(3), .LOSE_N(4), .TOL(8)) dut (
        .clk_50m   (clk_50m),
        .cfg_rst_n (cfg_rst_n),
        .sync_clr  (sync_clr),
        .cfg_thresh(cfg_thresh),
        .bus       (bus)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic push(input bit coarse, input int pos);
        exp_t e;
        e.coarse = coarse;
        e.pos    = 32'(pos);
        exp_q.push_back(e);
    endtask

    // Samples at cycle index i carry magnitude 10 except the two marked indices.
    task automatic send_samples(input int len, input int i1, input int m1, input int i2, input int m2);
        for (int i = 0; i < len; i++) begin
            tick();
            bus.corr_valid = 1'b1;
            bus.corr_mag   = (i == i1) ? MAG_W'(m1) : (i == i2) ? MAG_W'(m2) : MAG_W'(10);
        end
    endtask

    task automatic close_win(input bit v, input int m);
        tick();
        bus.win_start  = 1'b1;
        bus.corr_valid = v;
        bus.corr_mag   = MAG_W'(m);
        tick();
        bus.win_start  = 1'b0;
        bus.corr_valid = 1'b0;
        bus.corr_mag   = '0;
    endtask

    task automatic check_levels(input string tag, input int st, input int lose_exp);
        tick();
        check({tag, "_state"}, 32'(bus.det_state), 32'(st));
        check({tag, "_lose"}, 32'(bus.lose), 32'(lose_exp));
    endtask

    always @(negedge clk_50m) begin
        if (cfg_rst_n) begin
            if (bus.corase_syn_en && bus.fine_syn_en) begin
                check("both_strobes", 32'd1, 32'd0);
            end else if (bus.corase_syn_en || bus.fine_syn_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: coarse=%0b fine=%0b, required none (t=%0t)",
                             bus.corase_syn_en, bus.fine_syn_en, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_kind_coarse", 32'(bus.corase_syn_en), 32'(e.coarse));
                    check("strobe_pos", e.coarse ? bus.corase_syn_pos : bus.fine_syn_pos, e.pos);
                end
            end
        end
    end

    initial begin
        bus.win_start  = 1'b0;
        bus.corr_valid = 1'b0;
        bus.corr_mag   = '0;
        repeat (3) tick();
        check("rst_coarse_en", 32'(bus.corase_syn_en), 32'd0);
        check("rst_fine_en", 32'(bus.fine_syn_en), 32'd0);
        check("rst_coarse_pos", bus.corase_syn_pos, 32'd0);
        check("rst_state", 32'(bus.det_state), 32'd0);
        check("rst_lose", 32'(bus.lose), 32'd0);
        cfg_rst_n = 1'b1;
        tick();

        // T1: three windows with peak 500 at offset 37 -> coarse 37.
        close_win(0, 0);
        send_samples(120, 37, 500, -1, 0);
        close_win(0, 0);
        check_levels("t1_confirm", 1, 0);
        send_samples(120, 37, 500, -1, 0);
        close_win(0, 0);
        send_samples(120, 37, 500, -1, 0);
        push(1'b1, 37);
        close_win(0, 0);
        check_levels("t1_track", 2, 0);

        // T2: offsets 40 then 46 (46 is 9 from ref 37 unless ref follows).
        send_samples(120, 40, 500, -1, 0);
        push(1'b0, 40);
        close_win(0, 0);
        send_samples(120, 46, 500, -1, 0);
`ifdef SYN_TRACK_UPDATE_EN
        push(1'b0, 46);
`endif
        close_win(0, 0);
        check_levels("t2_track", 2, 0);
        send_samples(120, 42, 500, -1, 0);
        push(1'b0, 42);
        close_win(0, 0);

        // T3: four below-threshold windows -> lose on the fourth.
        for (int w = 0; w < 3; w++) begin
            send_samples(120, 5, 50, -1, 0);
            close_win(0, 0);
        end
        check_levels("t3_three_miss", 2, 0);
        send_samples(120, 5, 50, -1, 0);
        close_win(0, 0);
        check_levels("t3_lost", 0, 1);

        // T4: 37, 37 (peak == thresh), 90 restarts; two more at 90 -> coarse 90.
        send_samples(120, 37, 500, -1, 0);
        close_win(0, 0);
        send_samples(120, 37, 100, -1, 0);
        close_win(0, 0);
        send_samples(120, 90, 500, -1, 0);
        close_win(0, 0);
        check_levels("t4_restart", 1, 1);
        send_samples(120, 90, 500, -1, 0);
        close_win(0, 0);
        check_levels("t4_hit2", 1, 1);
        send_samples(120, 90, 500, -1, 0);
        push(1'b1, 90);
        close_win(0, 0);
        check_levels("t4_track", 2, 0);

        // T5: equal peaks at 85/95 -> 85; sample on win_start shifts later offsets by one.
        send_samples(120, 85, 500, 95, 500);
        push(1'b0, 85);
        close_win(1, 20);
        send_samples(120, 88, 600, -1, 0);
        push(1'b0, 89);
        close_win(0, 0);

        // T6: sync_clr with win_start suppresses the would-be fine strobe.
        send_samples(120, 90, 500, -1, 0);
        tick();
        sync_clr      = 1'b1;
        bus.win_start = 1'b1;
        tick();
        sync_clr      = 1'b0;
        bus.win_start = 1'b0;
        check_levels("t6_clr", 0, 0);
        send_samples(60, 37, 500, -1, 0);
        close_win(0, 0);
        check_levels("t6_first_open", 0, 0);
        send_samples(60, 37, 500, -1, 0);
        close_win(0, 0);
        check_levels("t6_hit", 1, 0);
        close_win(0, 0);
        check_levels("t6_empty_miss", 0, 0);
        send_samples(60, 37, 500, -1, 0);
        close_win(0, 0);
        check_levels("t6_rehit", 1, 0);

        // Asynchronous reset in the middle of a window.
        send_samples(20, 5, 500, -1, 0);
        #3 cfg_rst_n = 1'b0;
        #1;
        check("arst_coarse_pos", bus.corase_syn_pos, 32'd0);
        check("arst_fine_pos", bus.fine_syn_pos, 32'd0);
        check("arst_state", 32'(bus.det_state), 32'd0);
        check("arst_lose", 32'(bus.lose), 32'd0);
        check("arst_fine_en", 32'(bus.fine_syn_en), 32'd0);
        bus.corr_valid = 1'b0;
        repeat (2) tick();
        cfg_rst_n = 1'b1;
        repeat (4) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
